// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-to-1 arbitrated multiplexer.
// Contents:
//   N_REQ / SEL_W     - number of requesters and width of the select index
//   ST_IDLE / ST_BUSY - FSM state encodings
//   pick_t, rr_pick   - round-robin winner search starting at a given pointer
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request bit scanning ptr_v, ptr_v+1, ... modulo N_REQ.
  // The index addition wraps naturally because it is SEL_W bits wide.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req_v,
                                    input logic [SEL_W-1:0] ptr_v);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = {SEL_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr_v + SEL_W'(k);
      if (!res.found && req_v[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/Mux_8to1.sv
// Plain 8-to-1 single-bit multiplexer.
// Ports:
//   s - select index
//   d - eight data inputs
//   y - d[s]
module Mux_8to1
  import mux_arb_pkg::*;
(
  input  logic [SEL_W-1:0] s,
  input  logic [N_REQ-1:0] d,
  output logic             y
);

  assign y = d[s];

endmodule

// File: rtl/mux_8to1_arbiter.sv
// Round-robin arbitrated 8-to-1 multiplexer with a burst limit.
// Ports:
//   clk   - clock, all state changes on its rising edge
//   reset - asynchronous active-high reset
//   req   - request bit per requester
//   d     - data bit per requester
//   grant - registered one-hot grant, zero when idle
//   s     - registered select index of the granted requester
//   busy  - a grant is held
//   y     - d[s] while busy, 0 while idle
module mux_8to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic             y
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_BURST);

  logic [0:0]       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_s;
  logic [2:0]       r_cnt;
  logic [SEL_W-1:0] r_ptr;

  logic             w_busy;
  logic             w_release;
  logic [SEL_W-1:0] w_scan_ptr;
  pick_t            w_pick;
  logic [N_REQ-1:0] w_win_onehot;
  logic             w_mux_y;

  // Release decision and next-winner search. On a release the scan starts
  // just past the holder, so the holder ranks last and is only re-granted
  // when it is the sole requester left.
  always_comb begin
    w_busy = (r_state == ST_BUSY);
    if (w_busy && (!req[r_s] || (r_cnt == MAX_CNT))) begin
      w_release = 1'b1;
    end else begin
      w_release = 1'b0;
    end
    if (w_release) begin
      w_scan_ptr = r_s + 3'd1;
    end else begin
      w_scan_ptr = r_ptr;
    end
    w_pick       = rr_pick(req, w_scan_ptr);
    w_win_onehot = 8'd1 << w_pick.idx;
  end

  // FSM, grant/select registers, burst counter and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 8'd0;
      r_s     <= 3'd0;
      r_cnt   <= 3'd0;
      r_ptr   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick.found) begin
            r_state <= ST_BUSY;
            r_grant <= w_win_onehot;
            r_s     <= w_pick.idx;
            r_cnt   <= 3'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_ptr <= w_scan_ptr;
            if (w_pick.found) begin
              // Handover in the same edge, no idle gap.
              r_grant <= w_win_onehot;
              r_s     <= w_pick.idx;
              r_cnt   <= 3'd1;
            end else begin
              // s deliberately keeps its last value.
              r_state <= ST_IDLE;
              r_grant <= 8'd0;
              r_cnt   <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 8'd0;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  Mux_8to1 u_mux (
    .s (r_s),
    .d (d),
    .y (w_mux_y)
  );

  assign grant = r_grant;
  assign s     = r_s;
  assign busy  = w_busy;
  assign y     = w_mux_y & w_busy;

endmodule

// File: doc/mux_8to1_arbiter.md
MUX_8TO1_ARBITER -- requirements
Module: mux_8to1_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, legal range 1..7, giving the maximum consecutive cycles one requester holds the mux.
REQ-002 SHALL have port clk, input, 1, the single clock, with all state changing on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port req, input, 8, with bit i set while requester i wants the shared output.
REQ-005 SHALL have port d, input, 8, the data bit of requester i on d[i].
REQ-006 SHALL have port grant, output, 8, one-hot registered grant, or all-zero when idle.
REQ-007 SHALL have port s, output, 3, registered mux select equal to the index of the granted requester.
REQ-008 SHALL have port busy, output, 1, asserted while any grant is held.
REQ-009 SHALL have port y, output, 1, the shared output, equal to d[s] when busy and 0 when idle.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (grant=0, busy=0) and BUSY (exactly one grant bit set).
REQ-011 SHALL keep a round-robin pointer ptr[2:0]; arbitration picks the first set req bit scanning ptr, ptr+1, ... modulo 8.
REQ-012 SHALL, in IDLE with any req bit sampled high, register grant/s for the winner, set busy and cnt=1, and enter BUSY on that edge (one-cycle request-to-grant latency).
REQ-013 SHALL, in BUSY, increment cnt each edge while req[s] is high and cnt<MAX_BURST.
REQ-014 SHALL release the grant at the edge where req[s] is sampled low, or where cnt==MAX_BURST is sampled; either way the holder keeps the grant for at most MAX_BURST cycles.
REQ-015 SHALL set ptr=s+1 modulo 8 (7 wraps to 0) on every release.
REQ-016 SHALL, on release with any other req pending, register the next winner in the same edge, using the scan from the new ptr with no idle gap; the releasing requester ranks lowest.
REQ-017 SHALL, on release with no req pending (including the releasing requester), return to IDLE with grant=0, busy=0, and s holding its last value.
REQ-018 SHALL, on release by burst limit while the holder still requests and no other req bit is set, re-grant the same requester with cnt=1.
REQ-019 SHALL ignore req changes of non-granted requesters until the next arbitration edge; y SHALL follow d[s] combinationally while busy.
REQ-020 SHALL never assert more than one grant bit, and s SHALL always equal the encoded grant while busy.

Reset
REQ-021 SHALL, on asserting reset, immediately clear grant to 0, set s=0, busy=0, cnt=0 and ptr=0, and set state to IDLE, including in the middle of a grant.
REQ-022 SHALL resume arbitration at the first rising clk edge after reset deasserts, starting the scan from requester 0.

Structure
REQ-023 SHALL place N_REQ=8, SEL_W=3 and the IDLE/BUSY state encodings in shared package mux_arb_pkg.
REQ-024 SHALL instantiate the existing Mux_8to1 (s, d, y) as its only sub-module, with its output gated by busy to form y.
REQ-025 SHALL keep the arbitration, the counter and the FSM in the top module, with no latches.

Verification
REQ-026 Bench SHALL cover: reset release, req=8'b00000100, d=8'b10010101 -> next edge grant=8'b00000100, s=3'd2, busy=1, y=1.
REQ-027 Bench SHALL cover: req=8'hFF held, MAX_BURST=4 -> grants 0,1,...,7,0 each held exactly 4 cycles, with back-to-back handover and no idle cycle.
REQ-028 Bench SHALL cover: requester 5 alone drops req after 2 granted cycles -> grant cleared at the following edge, busy=0, ptr=6.
REQ-029 Bench SHALL cover: requester 7 granted with req[0] and req[6] pending -> release picks 0 (wrap-around), then 6.
REQ-030 Bench SHALL cover: requester 3 alone, req held for 10 cycles -> released and re-granted at cycles 4 and 8 with busy never dropping.
REQ-031 Bench SHALL cover: reset asserted mid-clock during a grant of requester 4 -> grant=0, s=0, busy=0, y=0 without waiting for a clk edge.
